// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 keyboard emulator: buffers key events and serialises them as
// 11-bit PS/2 frames, expanding a release into an F0 prefix frame plus the code frame.
module ps2_keyboard_tx #(
   parameter int CLK_DIV    = 8,
   parameter int GAP_CYCLES = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   input  logic       key_break,
   output logic       key_ready,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy,
   output logic [7:0] frame_cnt
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_LOW  = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   logic [8:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   occ_reg;
   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;
   logic [8:0]       fifo_head;

   logic [1:0]       state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [3:0]       bit_reg;
   logic [10:0]      frame_reg;
   logic [7:0]       saved_code_reg;
   logic             pending_reg;
   logic             ps2_clk_reg;
   logic             ps2_data_reg;
   logic [7:0]       frame_cnt_reg;

   function automatic logic [10:0] make_frame(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

   assign fifo_empty = (occ_reg == '0);
   assign fifo_full  = (occ_reg == OCC_FULL);
   assign fifo_head  = fifo_mem[rd_ptr_reg];
   assign push       = key_valid && !fifo_full;
   // A pending F0 follow-up outranks the FIFO so a release stays back-to-back.
   assign pop        = (state_reg == ST_IDLE) && !pending_reg && !fifo_empty;

   assign key_ready  = !fifo_full;
   assign ps2_clk    = ps2_clk_reg;
   assign ps2_data   = ps2_data_reg;
   assign frame_cnt  = frame_cnt_reg;
   assign busy       = !fifo_empty || (state_reg != ST_IDLE) || pending_reg;

   // Storage has no reset; only the pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {key_break, key_code};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ_reg <= occ_reg + (PTR_W + 1)'(1);
            2'b01:   occ_reg <= occ_reg - (PTR_W + 1)'(1);
            default: occ_reg <= occ_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= ST_IDLE;
         cnt_reg        <= '0;
         bit_reg        <= '0;
         frame_reg      <= '1;
         saved_code_reg <= '0;
         pending_reg    <= 1'b0;
         frame_cnt_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (pending_reg) begin
                  frame_reg   <= make_frame(saved_code_reg);
                  pending_reg <= 1'b0;
                  bit_reg     <= '0;
                  cnt_reg     <= '0;
                  state_reg   <= ST_HIGH;
               end else if (!fifo_empty) begin
                  if (fifo_head[8]) begin
                     frame_reg      <= make_frame(8'hF0);
                     saved_code_reg <= fifo_head[7:0];
                     pending_reg    <= 1'b1;
                  end else begin
                     frame_reg <= make_frame(fifo_head[7:0]);
                  end
                  bit_reg   <= '0;
                  cnt_reg   <= '0;
                  state_reg <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_LOW;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_LOW: begin
               if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
                  cnt_reg <= '0;
                  if (bit_reg == 4'd10) begin
                     frame_cnt_reg <= frame_cnt_reg + 8'd1;
                     state_reg     <= ST_GAP;
                  end else begin
                     bit_reg   <= bit_reg + 4'd1;
                     state_reg <= ST_HIGH;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         endcase
      end
   end

   // Line outputs are registered decodes of the FSM, so the pins trail the state by
   // one cycle and never glitch; data only moves when the bit index advances.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ps2_clk_reg  <= 1'b1;
         ps2_data_reg <= 1'b1;
      end else begin
         ps2_clk_reg  <= (state_reg != ST_LOW);
         ps2_data_reg <= ((state_reg == ST_HIGH) || (state_reg == ST_LOW)) ?
                         frame_reg[bit_reg] : 1'b1;
      end
   end
endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: a falling-edge PS/2 monitor decodes frames and checks
// them against a queue of expected bytes filled as key events are offered.
`timescale 1ns/1ps
module tb_ps2_keyboard_tx;
   localparam int CLK_DIV    = 8;
   localparam int GAP_CYCLES = 16;
   localparam int FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       key_valid = 1'b0;
   logic [7:0] key_code = 8'h00;
   logic       key_break = 1'b0;
   logic       key_ready;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;
   logic [7:0] frame_cnt;

   int         vec_cnt = 0;
   int         err_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_fc = 8'h00;
   logic [7:0] mon_exp;

   time        t_acc = 0, t_start = 0, t_first_fall = 0, t_fall_prev = 0;
   time        t_stop_end = 0, t_ready = 0;
   int         last_gap = 0;
   int         nbit = 0;
   int         frames_seen = 0;
   logic       prev_clk = 1'b1;
   logic       prev_data = 1'b1;
   logic [10:0] sh = '0;
   logic [7:0] burst_codes [6] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

   ps2_keyboard_tx #(
      .CLK_DIV(CLK_DIV),
      .GAP_CYCLES(GAP_CYCLES),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .key_valid(key_valid),
      .key_code(key_code),
      .key_break(key_break),
      .key_ready(key_ready),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .busy(busy),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Host-side receiver model: samples data on each ps2_clk falling edge.
   always @(negedge clk) begin
      if (!resetn) begin
         nbit      = 0;
         prev_clk  = ps2_clk;
         prev_data = ps2_data;
      end else begin
         if (nbit == 0 && prev_data && !ps2_data && ps2_clk) begin
            t_start  = $time;
            last_gap = int'((t_start - t_stop_end) / 10);
         end
         if (prev_clk && !ps2_clk) begin
            if (nbit == 0) begin
               t_first_fall = $time;
            end else begin
               check_val("fall_spacing", 32'((($time - t_fall_prev) / 10)), 32'(2 * CLK_DIV));
            end
            t_fall_prev = $time;
            sh[nbit]    = ps2_data;
            nbit++;
            if (nbit == 11) begin
               check_val("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
               if (exp_q.size() > 0) begin
                  mon_exp = exp_q.pop_front();
                  check_val("frame", 32'(sh), 32'({1'b1, ~^mon_exp, mon_exp, 1'b0}));
               end
               if (frames_seen == 0) check_val("mk1c_bits", 32'(sh), 32'(11'b1_0_00011100_0));
               if (frames_seen == 1) check_val("f0_bits", 32'(sh), 32'(11'b1_1_11110000_0));
               $display("frame %0d: data 0x%02h bits 0x%03h", frames_seen, sh[8:1], sh);
               frames_seen++;
               nbit = 0;
            end
         end
         if (!prev_clk && ps2_clk && nbit == 0) t_stop_end = $time;
         prev_clk  = ps2_clk;
         prev_data = ps2_data;
      end
   end

   task automatic send_key(input logic [7:0] code, input logic brk);
      int n = 0;
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = code;
      key_break = brk;
      while (!key_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_val("ready_wait", 32'(key_ready), 32'd1);
      if (key_ready) begin
         if (n > 0) t_ready = $time;
         if (brk) begin
            exp_q.push_back(8'hF0);
            exp_fc = exp_fc + 8'd2;
         end else begin
            exp_fc = exp_fc + 8'd1;
         end
         exp_q.push_back(code);
         @(posedge clk);
         t_acc = $time;
      end
      #1;
      key_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_val("idle_timeout", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      exp_q.delete();
      exp_fc = 8'h00;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_val("rst_key_ready", 32'(key_ready), 32'd1);
      check_val("rst_ps2_clk", 32'(ps2_clk), 32'd1);
      check_val("rst_ps2_data", 32'(ps2_data), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Single make, idle FSM: latency and first falling edge
      send_key(8'h1C, 1'b0);
      wait_idle();
      check_val("start_latency", 32'((t_start - t_acc - 5) / 10), 32'd2);
      check_val("first_fall", 32'((t_first_fall - t_acc - 5) / 10), 32'(2 + CLK_DIV));
      check_val("mk_frame_cnt", 32'(frame_cnt), 32'(exp_fc));

      // Release: F0 then code, separated by GAP_CYCLES+1
      send_key(8'h1C, 1'b1);
      wait_idle();
      check_val("brk_gap", 32'(last_gap), 32'(GAP_CYCLES + 1));
      check_val("brk_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      check_val("brk_sb_empty", 32'(exp_q.size()), 32'd0);

      // Burst of six makes: five accepted back-to-back, then full
      for (int i = 0; i < 5; i++) send_key(burst_codes[i], 1'b0);
      @(negedge clk);
      check_val("burst_full", 32'(key_ready), 32'd0);
      send_key(burst_codes[5], 1'b0);
      repeat (2) @(negedge clk);
      check_val("pop_ready_lag", 32'((t_start - t_ready) / 10), 32'd1);
      wait_idle();
      check_val("burst_sb_empty", 32'(exp_q.size()), 32'd0);
      check_val("burst_frame_cnt", 32'(frame_cnt), 32'(exp_fc));

      // Asynchronous reset mid-frame, with pending F0 follow-up and a queued event
      send_key(8'h5A, 1'b1);
      send_key(8'h44, 1'b0);
      n = 0;
      while (nbit < 5 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_val("reach_bit5", 32'(nbit >= 5), 32'd1);
      #2;
      check_val("pre_rst_clk", 32'(ps2_clk), 32'd0);
      resetn = 1'b0;
      exp_q.delete();
      exp_fc = 8'h00;
      #1;
      check_val("arst_ps2_clk", 32'(ps2_clk), 32'd1);
      check_val("arst_ps2_data", 32'(ps2_data), 32'd1);
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_val("arst_key_ready", 32'(key_ready), 32'd1);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      check_val("post_rst_busy", 32'(busy), 32'd0);
      send_key(8'h33, 1'b0);
      wait_idle();
      check_val("post_rst_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      check_val("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

      // 256 makes wrap frame_cnt back to zero
      do_reset();
      for (int i = 0; i < 256; i++) send_key(8'(i), 1'b0);
      wait_idle();
      check_val("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
      check_val("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
      check_val("wrap_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
